// File: rtl/el2_pkg.sv
// Trace packet and trace-buffer entry types shared by the trace buffer slice.
package el2_pkg;

  localparam int TRACE_PKT_W = 104;

  // One retirement record as emitted by the core trace port.
  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  // Stored form: the valid bit is implied by occupancy, so its slot carries
  // the "packets were lost just before this one" marker instead.
  typedef struct packed {
    logic        lost;
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_buf_entry_t;

  function automatic el2_trace_buf_entry_t trace_to_entry(input el2_trace_pkt_t pkt,
                                                          input logic lost);
    el2_trace_buf_entry_t e;
    e.lost                    = lost;
    e.trace_rv_i_insn_ip      = pkt.trace_rv_i_insn_ip;
    e.trace_rv_i_address_ip   = pkt.trace_rv_i_address_ip;
    e.trace_rv_i_exception_ip = pkt.trace_rv_i_exception_ip;
    e.trace_rv_i_ecause_ip    = pkt.trace_rv_i_ecause_ip;
    e.trace_rv_i_interrupt_ip = pkt.trace_rv_i_interrupt_ip;
    e.trace_rv_i_tval_ip      = pkt.trace_rv_i_tval_ip;
    return e;
  endfunction

  function automatic el2_trace_pkt_t entry_to_trace(input el2_trace_buf_entry_t e,
                                                    input logic valid);
    el2_trace_pkt_t pkt;
    pkt.trace_rv_i_insn_ip      = e.trace_rv_i_insn_ip;
    pkt.trace_rv_i_address_ip   = e.trace_rv_i_address_ip;
    pkt.trace_rv_i_valid_ip     = valid;
    pkt.trace_rv_i_exception_ip = e.trace_rv_i_exception_ip;
    pkt.trace_rv_i_ecause_ip    = e.trace_rv_i_ecause_ip;
    pkt.trace_rv_i_interrupt_ip = e.trace_rv_i_interrupt_ip;
    pkt.trace_rv_i_tval_ip      = e.trace_rv_i_tval_ip;
    return pkt;
  endfunction

endpackage

// File: rtl/el2_trace_buf_mem.sv
// Trace buffer storage: DEPTH x W flops, one write port, one combinational read port.
module el2_trace_buf_mem
  import el2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = TRACE_PKT_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/el2_trace_buf.sv
// Elastic buffer behind the core trace port: queues retirement packets,
// drains them to a trace sink and marks/counts packets lost to backpressure.
//
// Sink handshake: an entry transfers on any cycle where out_valid & out_ready
// are both high. While out_valid is high and out_ready is low, out_pkt and
// out_lost hold stable; out_valid only falls after a pop, a flush or reset.
module el2_trace_buf
  import el2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   trace_en,
  input  logic                   flush,
  input  el2_trace_pkt_t         trace_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output el2_trace_pkt_t         out_pkt,
  output logic                   out_lost,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic                 pend_lost;
  logic                 empty, full, req, pop, push, drop;
  el2_trace_buf_entry_t wr_entry, head;
  logic [TRACE_PKT_W-1:0] rd_data;

  assign req   = trace_en & (trace_in.trace_rv_i_valid_ip |
                             trace_in.trace_rv_i_exception_ip |
                             trace_in.trace_rv_i_interrupt_ip) & ~flush;
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign pop   = out_valid & out_ready;
  // A full buffer that is draining this cycle still has room for the new packet.
  assign push  = req & (~full | pop);
  assign drop  = req & full & ~pop;

  assign wr_entry = trace_to_entry(trace_in, pend_lost);

  el2_trace_buf_mem #(
    .DEPTH (DEPTH),
    .W     (TRACE_PKT_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  assign head      = rd_data;
  assign out_valid = ~empty;
  assign out_pkt   = entry_to_trace(head, out_valid);
  assign out_lost  = out_valid & head.lost;
  assign level     = wr_ptr - rd_ptr;

  // Pointer, loss-marker and drop-statistics update; flush overrides everything.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pend_lost <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pend_lost <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop) begin
        overflow  <= 1'b1;
        pend_lost <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end else if (push) begin
        pend_lost <= 1'b0;
      end
    end
  end

endmodule

// File: doc/el2_trace_buf.md
Name: el2_trace_buf

Overview:
- Elastic buffer that sits directly downstream of the core trace port.
- Captures per-retirement trace packets (type el2_trace_pkt_t) and holds them in a small FIFO.
- Drains them to an external trace sink over a valid/ready handshake.
- Detects and counts packets lost to backpressure, so the sink can resynchronise.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the dropped-packet counter.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- trace_en  in  1  capture enable; 0 ignores all input packets
- flush  in  1  synchronous clear of FIFO, lost flag, overflow and drop count
- trace_in  in  el2_trace_pkt_t (104)  packet from core trace port
- out_valid  out  1  head entry available
- out_ready  in  1  sink accepts head entry this cycle
- out_pkt  out  el2_trace_pkt_t (104)  head entry; trace_rv_i_valid_ip forced to 1 when out_valid
- out_lost  out  1  one or more packets were dropped immediately before this entry
- overflow  out  1  sticky; set on any drop
- drop_cnt  out  CNT_W  saturating count of dropped packets
- level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Capture request (req):
  - req = trace_en & (trace_rv_i_valid_ip | trace_rv_i_exception_ip | trace_rv_i_interrupt_ip) & ~flush.
  - Stored entry = all packet fields except valid, plus a lost bit; 104 bits total.
- Pop: pop = out_valid & out_ready.
- Push: push = req & (~full | pop). Full with a simultaneous pop accepts the new packet; level stays DEPTH.
- Drop: drop = req & full & ~pop.
  - overflow <= 1.
  - drop_cnt <= drop_cnt + 1, saturating at all-ones.
  - Internal pend_lost <= 1.
- Lost marker:
  - Each pushed entry's lost bit = pend_lost.
  - pend_lost clears on that push.
  - If a drop and a push coincide (impossible by construction), drop wins.
- Pointers:
  - rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits and wrap naturally.
  - empty = (rd_ptr == wr_ptr).
  - full = MSBs differ and the lower bits are equal.
  - level = wr_ptr - rd_ptr.
- Output timing:
  - out_valid = ~empty. out_pkt and out_lost are read combinationally from mem[rd_ptr], so there is no added output register.
  - Latency: a packet pushed in cycle N is visible on out_valid in cycle N+1.
  - No bypass when empty.
- Handshake rules:
  - out_pkt and out_lost hold stable while out_valid & ~out_ready.
  - A sink must not rely on out_valid dropping without a pop or flush.
- Flush (highest priority):
  - Same cycle: nothing is pushed or popped.
  - Next cycle: pointers = 0, overflow = 0, drop_cnt = 0, pend_lost = 0.
  - A pop signalled in the flush cycle is discarded.
- Reset (async assert, any time, including mid-handshake):
  - Pointers = 0, pend_lost = 0.
  - Outputs: out_valid = 0, out_lost = 0, overflow = 0, drop_cnt = 0, level = 0.
  - Memory contents are not reset; out_pkt is don't-care while out_valid = 0.
- trace_en deasserted: queued entries continue to drain; no new pushes; no drops counted.

Decomposition:
- el2_pkg additions:
  - el2_trace_buf_entry_t: the trace fields minus valid, plus the lost bit.
  - Localparam TRACE_PKT_W = 104.
- Sub-module el2_trace_buf_mem: DEPTH x entry flop array, one write port, one combinational read port, clocked by clk. No reset.
- Top block contains pointer and flag logic only.

Test Plan:
- Basic flow:
  - Stimulus: DEPTH=4, out_ready=1; push insn 0x00000013 at address 0x80000000.
  - Required: out_valid one cycle later; out_pkt address 0x80000000; out_lost=0; level returns 0 after the pop.
- Overflow:
  - Stimulus: out_ready=0; push 6 packets.
  - Required: level=4, overflow=1, drop_cnt=2.
  - Then set out_ready=1 and push a 7th packet. Required: the first 4 entries have out_lost=0; the 7th has out_lost=1.
- Full with simultaneous push and pop:
  - Stimulus: level=4, out_ready=1, req=1 in the same cycle.
  - Required: push accepted, level stays 4, drop_cnt unchanged.
- Exception-only packet:
  - Stimulus: valid=0, exception=1, ecause=5'd2, tval=0xDEADBEEF.
  - Required: entry captured; out_pkt valid bit = 1; ecause=2; tval=0xDEADBEEF.
- Saturation, then flush:
  - Stimulus: CNT_W=4, force 20 drops.
  - Required: drop_cnt=4'hF.
  - Then assert flush with out_ready=1. Required next cycle: level=0, overflow=0, drop_cnt=0.
- Async reset mid-stall:
  - Stimulus: level=3 and out_valid & ~out_ready when rst_l falls.
  - Required, immediately: out_valid=0, level=0.
  - After release: the first new push has out_lost=0.
